// File: rtl/mag_scheduler_pkg.sv
// Shared definitions for the magnitude scheduler: datapath width, FSM
// state type and the requester-ID width helper.
package mag_scheduler_pkg;

  localparam int unsigned CALU_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Requester ID width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_scheduler_if.sv
// Requester, magnitude-unit and result channels of the magnitude scheduler.
// master: the surrounding environment (operand sources, magnitude unit,
// result consumer). slave: the scheduler itself.
interface mag_scheduler_if
  import mag_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*CALU_DW-1:0] req_real;
  logic [NREQ*CALU_DW-1:0] req_imag;
  logic [CALU_DW-1:0]      mag_real;
  logic [CALU_DW-1:0]      mag_imag;
  logic [CALU_DW-1:0]      mag_result;
  logic                    out_valid;
  logic                    out_ready;
  logic [CALU_DW-1:0]      out_mag;
  logic [IDW-1:0]          out_id;

  modport master (
    output req_valid, req_real, req_imag, mag_result, out_ready,
    input  req_ready, mag_real, mag_imag, out_valid, out_mag, out_id
  );

  modport slave (
    input  req_valid, req_real, req_imag, mag_result, out_ready,
    output req_ready, mag_real, mag_imag, out_valid, out_mag, out_id
  );

endinterface

// File: rtl/mag_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted requester and wraps; produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] w_idx;
  logic           w_found;

  // First requesting index after last_grant, modulo NREQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = IDW'((32'(last_grant) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found     = 1'b1;
        grant[w_idx] = 1'b1;
        grant_id    = w_idx;
      end
    end
  end

endmodule

// File: rtl/mag_scheduler.sv
// Round-robin scheduler sharing one magnitude unit among NREQ requesters.
// Optional MAG_SCHED_STATS_EN adds a 16-bit completed-transfer counter.
module mag_scheduler
  import mag_scheduler_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAG_LAT = 0,
  parameter int unsigned IDW     = id_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  mag_scheduler_if.slave      bus,
`ifdef MAG_SCHED_STATS_EN
  output logic [15:0]         op_count,
`endif
  output logic                busy
);

  localparam int unsigned WCW = (MAG_LAT > 0) ? $clog2(MAG_LAT + 1) : 1;

  state_t             r_state, w_next;
  logic [IDW-1:0]     r_last_grant, r_op_id, r_out_id, w_grant_id;
  logic [NREQ-1:0]    w_grant;
  logic [CALU_DW-1:0] r_op_real, r_op_imag, r_out_mag;
  logic [CALU_DW-1:0] w_sel_real, w_sel_imag;
  logic [WCW-1:0]     r_wcnt;
  logic               w_hs, w_done, w_acc;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (bus.req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_id   (w_grant_id)
  );

  assign w_hs   = (r_state == IDLE) && !rst && (|w_grant);
  assign w_done = (r_state == WAIT) && (r_wcnt == WCW'(MAG_LAT));
  assign w_acc  = (r_state == OUT) && bus.out_ready;

  assign bus.mag_real = r_op_real;
  assign bus.mag_imag = r_op_imag;
  assign bus.out_mag  = r_out_mag;
  assign bus.out_id   = r_out_id;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_real = '0;
    w_sel_imag = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_real = bus.req_real[i*CALU_DW +: CALU_DW];
        w_sel_imag = bus.req_imag[i*CALU_DW +: CALU_DW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs; grants only in IDLE and out of reset.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (!rst) bus.req_ready = w_grant;
        if (w_hs) w_next = WAIT;
      end
      WAIT: if (w_done) w_next = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture on handshake, latency count, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IDW'(NREQ - 1);
      r_op_real    <= '0;
      r_op_imag    <= '0;
      r_op_id      <= '0;
      r_wcnt       <= '0;
      r_out_mag    <= '0;
      r_out_id     <= '0;
    end else begin
      if (w_hs) begin
        r_op_real    <= w_sel_real;
        r_op_imag    <= w_sel_imag;
        r_op_id      <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_wcnt       <= '0;
      end else if (r_state == WAIT) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_done) begin
        r_out_mag <= bus.mag_result;
        r_out_id  <= r_op_id;
      end
    end
  end

`ifdef MAG_SCHED_STATS_EN
  // Completed-transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)        op_count <= '0;
    else if (w_acc) op_count <= op_count + 16'd1;
  end
`else
  logic w_acc_unused;
  assign w_acc_unused = w_acc;
`endif

endmodule

// File: tb/tb_mag_scheduler.sv
// Directed self-checking bench for mag_scheduler: a combinational
// instance (MAG_LAT=0) and a two-stage-latency instance (MAG_LAT=2),
// each with a behavioural magnitude model attached.
module tb_mag_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy_a, busy_b;
`ifdef MAG_SCHED_STATS_EN
  logic [15:0] op_count_a, op_count_b;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mag_scheduler_if #(.NREQ(4), .IDW(2)) ia ();
  mag_scheduler_if #(.NREQ(4), .IDW(2)) ib ();

  mag_scheduler #(.NREQ(4), .MAG_LAT(0), .IDW(2)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .bus      (ia),
`ifdef MAG_SCHED_STATS_EN
    .op_count (op_count_a),
`endif
    .busy     (busy_a)
  );

  mag_scheduler #(.NREQ(4), .MAG_LAT(2), .IDW(2)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (ib),
`ifdef MAG_SCHED_STATS_EN
    .op_count (op_count_b),
`endif
    .busy     (busy_b)
  );

  function automatic logic [15:0] isqrt(input logic [15:0] re, input logic [15:0] im);
    logic [31:0] x, r, t;
    x = 32'(re) * 32'(re) + 32'(im) * 32'(im);
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[15:0];
  endfunction

  // Magnitude models: combinational for A, two register stages for B.
  logic [15:0] b_s1 = '0, b_s2 = '0;
  assign ia.mag_result = isqrt(ia.mag_real, ia.mag_imag);
  always @(posedge clk) begin
    b_s1 <= isqrt(ib.mag_real, ib.mag_imag);
    b_s2 <= b_s1;
  end
  assign ib.mag_result = b_s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op_a(input int i, input logic [15:0] re, input logic [15:0] im);
    ia.req_real[i*16 +: 16] = re;
    ia.req_imag[i*16 +: 16] = im;
  endtask

  int exp_mag [4] = '{5, 13, 10, 0};

  initial begin
    ia.req_valid = '0; ia.req_real = '0; ia.req_imag = '0; ia.out_ready = 1'b1;
    ib.req_valid = '0; ib.req_real = '0; ib.req_imag = '0; ib.out_ready = 1'b1;

    // Reset state, and no grant while rst is high.
    step(); step();
    ia.req_valid = 4'b0001;
    #4;
    check("rst_req_ready", 32'(ia.req_ready), 0);
    check("rst_out_valid", 32'(ia.out_valid), 0);
    check("rst_busy",      32'(busy_a), 0);
    check("rst_out_mag",   32'(ia.out_mag), 0);
    check("rst_out_id",    32'(ia.out_id), 0);
    check("rst_mag_real",  32'(ia.mag_real), 0);
    check("rst_mag_imag",  32'(ia.mag_imag), 0);
`ifdef MAG_SCHED_STATS_EN
    check("rst_op_count",  32'(op_count_a), 0);
`endif
    ia.req_valid = '0;
    rst = 1'b0;
    step();

    // Single request from requester 2: (3,4) -> 5.
    set_op_a(2, 16'd3, 16'd4);
    ia.req_valid = 4'b0100;
    #4;
    check("t1_ready",  32'(ia.req_ready), 32'b0100);
    check("t1_busy0",  32'(busy_a), 0);
    step();
    ia.req_valid = '0;
    #4;
    check("t1_wait_valid", 32'(ia.out_valid), 0);
    check("t1_wait_busy",  32'(busy_a), 1);
    check("t1_mag_real",   32'(ia.mag_real), 3);
    check("t1_mag_imag",   32'(ia.mag_imag), 4);
    step();
    #4;
    check("t1_out_valid", 32'(ia.out_valid), 1);
    check("t1_out_mag",   32'(ia.out_mag), 5);
    check("t1_out_id",    32'(ia.out_id), 2);
    step();
    #4;
    check("t1_idle_valid", 32'(ia.out_valid), 0);
    check("t1_idle_busy",  32'(busy_a), 0);
    step();

    // All four requesting after reset: served 0,1,2,3, one per 3 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op_a(0, 16'd3, 16'd4);
    set_op_a(1, 16'd5, 16'd12);
    set_op_a(2, 16'd8, 16'd6);
    set_op_a(3, 16'd0, 16'd0);
    ia.req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #4;
      check("t2_ready", 32'(ia.req_ready), 32'(1 << k));
      step();
      ia.req_valid[k] = 1'b0;
      #4;
      check("t2_wait_valid", 32'(ia.out_valid), 0);
      step();
      #4;
      check("t2_out_valid", 32'(ia.out_valid), 1);
      check("t2_out_mag",   32'(ia.out_mag), 32'(exp_mag[k]));
      check("t2_out_id",    32'(ia.out_id), 32'(k));
      step();
    end
    #4;
    check("t2_idle_busy", 32'(busy_a), 0);
`ifdef MAG_SCHED_STATS_EN
    check("t2_op_count", 32'(op_count_a), 4);
`endif
    step();

    // Backpressure: requester 1 (8,15) -> 17, out_ready low for 10 cycles.
    set_op_a(1, 16'd8, 16'd15);
    ia.out_ready = 1'b0;
    ia.req_valid = 4'b0010;
    #4;
    check("t3_ready", 32'(ia.req_ready), 32'b0010);
    step();
    ia.req_valid = 4'b1111;
    #4;
    check("t3_wait_ready", 32'(ia.req_ready), 0);
    step();
    for (int c = 0; c < 10; c++) begin
      #4;
      check("t3_bp_valid", 32'(ia.out_valid), 1);
      check("t3_bp_mag",   32'(ia.out_mag), 17);
      check("t3_bp_id",    32'(ia.out_id), 1);
      check("t3_bp_ready", 32'(ia.req_ready), 0);
      check("t3_bp_busy",  32'(busy_a), 1);
      step();
    end
    ia.out_ready = 1'b1;
    #4;
    check("t3_acc_valid", 32'(ia.out_valid), 1);
    step();
    #4;
    check("t3_idle_busy",  32'(busy_a), 0);
    check("t3_idle_valid", 32'(ia.out_valid), 0);
    check("t3_next_ready", 32'(ia.req_ready), 32'b0100);
    ia.req_valid = '0;
    step();

    // Reset during WAIT discards the operation and restarts at requester 0.
    set_op_a(3, 16'd5, 16'd12);
    ia.req_valid = 4'b1000;
    #4;
    check("t4_ready3", 32'(ia.req_ready), 32'b1000);
    step();
    ia.req_valid = '0;
    rst = 1'b1;
    #4;
    check("t4_rst_busy",  32'(busy_a), 1);
    check("t4_rst_ready", 32'(ia.req_ready), 0);
    step();
    rst = 1'b0;
    set_op_a(0, 16'd6, 16'd8);
    set_op_a(1, 16'd9, 16'd12);
    ia.req_valid = 4'b0011;
    #4;
    check("t4_after_valid", 32'(ia.out_valid), 0);
    check("t4_after_busy",  32'(busy_a), 0);
    check("t4_ready0",      32'(ia.req_ready), 32'b0001);
    step();
    ia.req_valid[0] = 1'b0;
    #4;
    check("t4_wait_valid", 32'(ia.out_valid), 0);
    step();
    #4;
    check("t4_out_mag0", 32'(ia.out_mag), 10);
    check("t4_out_id0",  32'(ia.out_id), 0);
    step();
    #4;
    check("t4_ready1", 32'(ia.req_ready), 32'b0010);
    step();
    ia.req_valid[1] = 1'b0;
    step();
    #4;
    check("t4_out_mag1", 32'(ia.out_mag), 15);
    check("t4_out_id1",  32'(ia.out_id), 1);
    step();

    // MAG_LAT=2: (5,12) -> 13 four cycles after the handshake.
    ib.req_real[15:0] = 16'd5;
    ib.req_imag[15:0] = 16'd12;
    ib.req_valid = 4'b0001;
    #4;
    check("t5_ready", 32'(ib.req_ready), 32'b0001);
    step();
    ib.req_valid = '0;
    for (int w = 0; w < 3; w++) begin
      #4;
      check("t5_wait_real",  32'(ib.mag_real), 5);
      check("t5_wait_imag",  32'(ib.mag_imag), 12);
      check("t5_wait_valid", 32'(ib.out_valid), 0);
      step();
    end
    #4;
    check("t5_out_valid", 32'(ib.out_valid), 1);
    check("t5_out_mag",   32'(ib.out_mag), 13);
    check("t5_out_id",    32'(ib.out_id), 0);
    step();
    #4;
    check("t5_idle_busy", 32'(busy_b), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
